// File: rtl/lock_code_checker.sv
// -----------------------------------------------------------------------------
// lock_code_checker
//
// Consumer side of the number-lock digit entry path. BCD digits arrive one per
// digit_valid pulse and are shifted into a DIGITS-long code buffer (MS digit
// first). An enter pulse launches a one-cycle compare against the password.
// A match opens the lock for OPEN_CYCLES clocks. A mismatch bumps the
// consecutive-error counter. When that counter reaches MAX_ERR, the block
// raises a lockout alarm for LOCKOUT_CYCLES clocks.
//
// Optional feature (macro PASSWORD_SET_EN):
//   Adds the set_pw input and a writable password register that resets to
//   PASSWORD. While OPEN, digits may be keyed in to form a new code. Each
//   accepted digit restarts the OPEN timer. set_pw with a full buffer copies
//   the buffer into the password register. Without the macro, the password
//   is the constant PASSWORD and OPEN ignores digits.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   digit_in     BCD digit (8421) from the digit counter
//   digit_valid  one-cycle pulse: capture digit_in
//   enter        one-cycle pulse: submit the entered code
//   clear        one-cycle pulse: discard entry, or relock when open
//   set_pw       (PASSWORD_SET_EN only) one-cycle pulse: store new password
//   unlock       registered, high for OPEN_CYCLES clocks after a match
//   alarm        registered, high for LOCKOUT_CYCLES clocks after lockout
//   err_cnt      consecutive wrong attempts
//   digit_cnt    digits currently held, saturates at DIGITS
// -----------------------------------------------------------------------------
module lock_code_checker #(
  parameter int                  DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] PASSWORD       = 16'h1234,
  parameter int                  MAX_ERR        = 3,
  parameter int                  OPEN_CYCLES    = 50,
  parameter int                  LOCKOUT_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       enter,
  input  logic       clear,
`ifdef PASSWORD_SET_EN
  input  logic       set_pw,
`endif
  output logic       unlock,
  output logic       alarm,
  output logic [2:0] err_cnt,
  output logic [3:0] digit_cnt
);

  localparam int BUF_W   = 4 * DIGITS;
  localparam int T_MAX   = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  localparam logic [TIMER_W-1:0] OPEN_T    = TIMER_W'(OPEN_CYCLES);
  localparam logic [TIMER_W-1:0] LOCK_T    = TIMER_W'(LOCKOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [3:0]         DIGITS_C  = 4'(DIGITS);
  localparam logic [2:0]         MAX_ERR_C = 3'(MAX_ERR);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    ALARM
  } state_t;

  state_t             state_q,     state_d;
  logic [BUF_W-1:0]   buf_q,       buf_d;
  logic [3:0]         digit_cnt_q, digit_cnt_d;
  logic [2:0]         err_cnt_q,   err_cnt_d;
  logic [TIMER_W-1:0] timer_q,     timer_d;
  logic               unlock_q,    unlock_d;
  logic               alarm_q,     alarm_d;

  logic [BUF_W-1:0]   pw;         // password currently in force
  logic [BUF_W-1:0]   buf_shift;  // buffer with digit_in appended as LS nibble
  logic [2:0]         err_inc;    // err_cnt after one more wrong attempt
  logic               digit_ok;   // legal BCD digit with room left in the buffer
  logic               code_match;

`ifdef PASSWORD_SET_EN
  logic [BUF_W-1:0]   pw_q, pw_d;
  assign pw = pw_q;
`else
  assign pw = PASSWORD;
`endif

  assign buf_shift  = (buf_q << 4) | BUF_W'(digit_in);
  assign err_inc    = err_cnt_q + 3'd1;
  assign digit_ok   = digit_valid && (digit_in <= 4'd9) && (digit_cnt_q < DIGITS_C);
  assign code_match = (digit_cnt_q == DIGITS_C) && (buf_q == pw);

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    digit_cnt_d = digit_cnt_q;
    err_cnt_d   = err_cnt_q;
    timer_d     = timer_q;
`ifdef PASSWORD_SET_EN
    pw_d        = pw_q;
`endif
    // The outputs follow the state register. They rise one edge after the
    // state enters OPEN or ALARM: enter at edge N gives CHECK after N,
    // OPEN after N+1, and unlock after N+2.
    unlock_d    = (state_q == OPEN);
    alarm_d     = (state_q == ALARM);

    case (state_q)
      IDLE, ENTRY: begin
        // Priority: clear > enter > digit_valid. A lower pulse is dropped.
        if (clear) begin
          buf_d       = '0;
          digit_cnt_d = '0;
          state_d     = IDLE;
        end else if (enter) begin
          if (state_q == ENTRY) state_d = CHECK;
        end else if (digit_ok) begin
          buf_d       = buf_shift;
          digit_cnt_d = digit_cnt_q + 4'd1;
          state_d     = ENTRY;
        end
      end

      CHECK: begin
        buf_d       = '0;
        digit_cnt_d = '0;
        if (code_match) begin
          state_d   = OPEN;
          err_cnt_d = '0;
          timer_d   = OPEN_T;
        end else begin
          err_cnt_d = err_inc;
          if (err_inc == MAX_ERR_C) begin
            state_d = ALARM;
            timer_d = LOCK_T;
          end else begin
            state_d = IDLE;
          end
        end
      end

      OPEN: begin
        // The timer holds the number of OPEN cycles left, including this one.
        if (timer_q <= TIMER_ONE) begin
          state_d     = IDLE;
          buf_d       = '0;
          digit_cnt_d = '0;
          timer_d     = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end

        if (clear) begin
          state_d     = IDLE;
          buf_d       = '0;
          digit_cnt_d = '0;
          timer_d     = '0;
`ifdef PASSWORD_SET_EN
        end else if (!enter) begin
          if (set_pw && (digit_cnt_q == DIGITS_C)) begin
            pw_d        = buf_q;
            buf_d       = '0;
            digit_cnt_d = '0;
          end else if (digit_ok) begin
            // New-code entry keeps the lock open: restart the full window.
            buf_d       = buf_shift;
            digit_cnt_d = digit_cnt_q + 4'd1;
            state_d     = OPEN;
            timer_d     = OPEN_T;
          end
`endif
        end
      end

      ALARM: begin
        // Lockout ignores every input and clears the error history on exit.
        if (timer_q <= TIMER_ONE) begin
          state_d   = IDLE;
          err_cnt_d = '0;
          timer_d   = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      default: begin
        state_d     = IDLE;
        buf_d       = '0;
        digit_cnt_d = '0;
        timer_d     = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the pre-edge values of the others regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      digit_cnt_q <= '0;
      err_cnt_q   <= '0;
      timer_q     <= '0;
      unlock_q    <= 1'b0;
      alarm_q     <= 1'b0;
`ifdef PASSWORD_SET_EN
      pw_q        <= PASSWORD;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      digit_cnt_q <= digit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      timer_q     <= timer_d;
      unlock_q    <= unlock_d;
      alarm_q     <= alarm_d;
`ifdef PASSWORD_SET_EN
      pw_q        <= pw_d;
`endif
    end
  end

  assign unlock    = unlock_q;
  assign alarm     = alarm_q;
  assign err_cnt   = err_cnt_q;
  assign digit_cnt = digit_cnt_q;

endmodule

// File: tb/tb_lock_code_checker.sv
// -----------------------------------------------------------------------------
// tb_lock_code_checker
//
// The driver applies one set of inputs per clock at the falling edge. It steps
// a behavioural model of the lock, kept as a digit queue plus countdowns, and
// pushes the outputs expected after the next rising edge into a scoreboard
// queue. The monitor pops one entry shortly after every rising edge and
// compares it with the DUT outputs. Directed scenarios run first, followed by
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_lock_code_checker;

  localparam int                  DIGITS         = 4;
  localparam logic [4*DIGITS-1:0] PASSWORD       = 16'h1234;
  localparam int                  MAX_ERR        = 3;
  localparam int                  OPEN_CYCLES    = 50;
  localparam int                  LOCKOUT_CYCLES = 100;
  localparam int                  VW             = 4 * DIGITS;
`ifdef PASSWORD_SET_EN
  localparam bit                  PW_SET         = 1'b1;
`else
  localparam bit                  PW_SET         = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit_in = '0;
  logic       digit_valid = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
`ifdef PASSWORD_SET_EN
  logic       set_pw = 1'b0;
`endif
  logic       unlock, alarm;
  logic [2:0] err_cnt;
  logic [3:0] digit_cnt;

  lock_code_checker #(
    .DIGITS(DIGITS), .PASSWORD(PASSWORD), .MAX_ERR(MAX_ERR),
    .OPEN_CYCLES(OPEN_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .enter(enter), .clear(clear),
`ifdef PASSWORD_SET_EN
    .set_pw(set_pw),
`endif
    .unlock(unlock), .alarm(alarm), .err_cnt(err_cnt), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  int pops     = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic       unlock;
    logic       alarm;
    logic [2:0] err;
    logic [3:0] cnt;
  } exp_t;

  exp_t           sb_q[$];
  int             m_digits[$];     // digits held, oldest first
  int             m_open_left;     // OPEN cycles remaining, 0 = not open
  int             m_alarm_left;    // lockout cycles remaining, 0 = no lockout
  int             m_errs;
  bit             m_pending;       // an enter was accepted; compare next cycle
  logic [VW-1:0]  m_pw;

  function automatic logic [VW-1:0] code_value();
    logic [VW-1:0] v = '0;
    foreach (m_digits[i]) v = (v << 4) | VW'(m_digits[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_open_left  = 0;
    m_alarm_left = 0;
    m_errs       = 0;
    m_pending    = 1'b0;
    m_pw         = PASSWORD;
  endtask

  // Advances the model by one rising edge. The outputs registered at that
  // edge reflect whether the lock was open or in lockout before the edge.
  task automatic model_step(input bit dv, input int d, input bit en,
                            input bit clr, input bit spw);
    exp_t e;
    bit   restarted;
    e.unlock = (m_open_left > 0);
    e.alarm  = (m_alarm_left > 0);
    if (m_alarm_left > 0) begin
      m_alarm_left--;
      if (m_alarm_left == 0) m_errs = 0;
    end else if (m_pending) begin
      m_pending = 1'b0;
      if (m_digits.size() == DIGITS && code_value() == m_pw) begin
        m_open_left = OPEN_CYCLES;
        m_errs      = 0;
      end else begin
        m_errs++;
        if (m_errs == MAX_ERR) m_alarm_left = LOCKOUT_CYCLES;
      end
      m_digits.delete();
    end else if (m_open_left > 0) begin
      if (clr) begin
        m_open_left = 0;
        m_digits.delete();
      end else begin
        restarted = 1'b0;
        if (PW_SET && !en) begin
          if (spw && m_digits.size() == DIGITS) begin
            m_pw = code_value();
            m_digits.delete();
          end else if (dv && d <= 9 && m_digits.size() < DIGITS) begin
            m_digits.push_back(d);
            restarted = 1'b1;
          end
        end
        if (restarted) m_open_left = OPEN_CYCLES;
        else begin
          m_open_left--;
          if (m_open_left == 0) m_digits.delete();
        end
      end
    end else begin
      if (clr) m_digits.delete();
      else if (en) begin
        if (m_digits.size() > 0) m_pending = 1'b1;
      end else if (dv && d <= 9 && m_digits.size() < DIGITS) m_digits.push_back(d);
    end
    e.err = 3'(m_errs);
    e.cnt = 4'(m_digits.size());
    sb_q.push_back(e);
    pushes++;
  endtask

  // ---------------- driver helpers ----------------
  task automatic step(input bit dv, input int d, input bit en,
                      input bit clr, input bit spw);
    @(negedge clk);
    digit_valid = dv;
    digit_in    = 4'(d);
    enter       = en;
    clear       = clr;
`ifdef PASSWORD_SET_EN
    set_pw      = spw;
`endif
    model_step(dv, d, en, clr, spw);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic type_code(input logic [31:0] code, input int n);
    for (int i = 0; i < n; i++) step(1'b1, int'((code >> (4 * (n - 1 - i))) & 32'hF), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_enter();
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  // Asserts rst_n away from any clock edge; the outputs must drop at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    digit_valid = 1'b0;
    enter       = 1'b0;
    clear       = 1'b0;
`ifdef PASSWORD_SET_EN
    set_pw      = 1'b0;
`endif
    #1;
    check("rst_unlock",    int'(unlock),    0);
    check("rst_alarm",     int'(alarm),     0);
    check("rst_err_cnt",   int'(err_cnt),   0);
    check("rst_digit_cnt", int'(digit_cnt), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        pops++;
        check("unlock",    int'(unlock),    int'(e.unlock));
        check("alarm",     int'(alarm),     int'(e.alarm));
        check("err_cnt",   int'(err_cnt),   int'(e.err));
        check("digit_cnt", int'(digit_cnt), int'(e.cnt));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();

    // Correct code opens the lock for the full window, then it relocks.
    type_code(32'h1234, 4);
    press_enter();
    idle(OPEN_CYCLES + 5);

    // Three wrong codes lead to lockout; inputs during lockout do nothing.
    for (int k = 0; k < MAX_ERR; k++) begin
      type_code(32'h1235, 4);
      press_enter();
      idle(3);
    end
    for (int k = 0; k < 20; k++)
      step(1'b1, k % 10, (k % 3) == 0, (k % 5) == 0, 1'b0);
    idle(LOCKOUT_CYCLES - 10);

    // A short code is a mismatch; extra digits beyond DIGITS are dropped.
    type_code(32'h123, 3);
    press_enter();
    idle(3);
    type_code(32'h12349, 5);
    press_enter();
    idle(OPEN_CYCLES + 5);

    // Non-BCD digit, then clear over enter, then enter over a digit.
    step(1'b1, 10, 1'b0, 1'b0, 1'b0);
    idle(1);
    type_code(32'h1234, 4);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    idle(3);
    type_code(32'h1234, 4);
    step(1'b1, 5, 1'b1, 1'b0, 1'b0);
    idle(OPEN_CYCLES + 5);

    // Reset in the middle of the open window.
    type_code(32'h1234, 4);
    press_enter();
    idle(21);
    do_reset();
    idle(3);

`ifdef PASSWORD_SET_EN
    // Change the password while open, then only the new code works.
    type_code(32'h1234, 4);
    press_enter();
    idle(3);
    type_code(32'h5678, 4);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(2);
    type_code(32'h1234, 4);
    press_enter();
    idle(3);
    type_code(32'h5678, 4);
    press_enter();
    idle(OPEN_CYCLES + 5);
`endif

    // Randomized traffic, biased towards the current password digits.
    for (int i = 0; i < 3000; i++) begin
      bit dv, en, clr, spw;
      int d;
      dv  = ($urandom_range(0, 99) < 45);
      en  = ($urandom_range(0, 99) < 8);
      clr = ($urandom_range(0, 99) < 3);
      spw = ($urandom_range(0, 99) < 4);
      if (m_digits.size() < DIGITS && $urandom_range(0, 3) != 0)
        d = int'((m_pw >> (4 * (DIGITS - 1 - m_digits.size()))) & VW'(15));
      else
        d = int'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) do_reset();
      else step(dv, d, en, clr, spw);
    end

    idle(2);
    @(posedge clk);
    #2;
    check("sb_drained", sb_q.size(), 0);
    check("sb_balance", pops, pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
